// File: rtl/ntt_butterfly_sequencer.sv
// In-place radix-2 NTT butterfly scheduler; define NTT_INVERSE_EN for descending-stage (inverse) order and tw_inv.
// Latency: first rd_en 2 cycles after start is presented, wr_en trails rd_en by PIPE_LAT, done after LOG_N*(N/2+PIPE_LAT)+2.
// Backpressure: stall freezes issue while running; the write delay line keeps shifting regardless.
module ntt_butterfly_sequencer #(
  parameter int LOG_N    = 8,
  parameter int PIPE_LAT = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             stall,
`ifdef NTT_INVERSE_EN
  input  logic             inverse,
  output logic             tw_inv,
`endif
  output logic             busy,
  output logic             done,
  output logic [3:0]       stage,
  output logic             rd_en,
  output logic [LOG_N-1:0] rd_addr_a,
  output logic [LOG_N-1:0] rd_addr_b,
  output logic [LOG_N-2:0] tw_addr,
  output logic             wr_en,
  output logic [LOG_N-1:0] wr_addr_a,
  output logic [LOG_N-1:0] wr_addr_b
);
  localparam int JW = LOG_N - 1;
  localparam int DW = $clog2(PIPE_LAT + 1);
  localparam logic [JW-1:0] J_LAST = '1;

  typedef enum logic [1:0] {IDLE, RUN, DRAIN, FIN} state_t;

  typedef struct packed {
    logic             en;
    logic [LOG_N-1:0] a;
    logic [LOG_N-1:0] b;
  } wrSlot_t;

  state_t           state, stateNxt;
  logic [JW-1:0]    jCnt, jNxt;
  logic [DW-1:0]    drainCnt, drainNxt;
  logic [3:0]       stageNxt, firstStage, stageStep;
  logic             lastStage;
  logic             busyNxt, doneNxt, rdEnNxt;
  logic [LOG_N-1:0] addrANxt, addrBNxt;
  logic [LOG_N-1:0] jWide, lowMask, issueA, issueB;
  logic [JW-1:0]    twNxt, issueTw;
  wrSlot_t [PIPE_LAT-1:0] delayLine;

`ifdef NTT_INVERSE_EN
  logic invLat;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      invLat <= 1'b0;
    end else if (state == IDLE && start) begin
      invLat <= inverse;
    end
  end

  assign tw_inv     = invLat;
  assign firstStage = inverse ? 4'(LOG_N - 1) : 4'd0;
  assign lastStage  = invLat ? (stage == 4'd0) : (stage == 4'(LOG_N - 1));
  assign stageStep  = invLat ? stage - 4'd1 : stage + 4'd1;
`else
  assign firstStage = 4'd0;
  assign lastStage  = (stage == 4'(LOG_N - 1));
  assign stageStep  = stage + 4'd1;
`endif

  // Butterfly (stage, j): splice a zero into j at bit 'stage' to get the upper operand.
  always_comb begin
    jWide   = {1'b0, jCnt};
    lowMask = (LOG_N'(1) << stage) - LOG_N'(1);
    issueA  = ((jWide & ~lowMask) << 1) | (jWide & lowMask);
    issueB  = issueA | (LOG_N'(1) << stage);
    issueTw = (jCnt & lowMask[JW-1:0]) << (4'(LOG_N - 1) - stage);
  end

  always_comb begin
    stateNxt = state;
    jNxt     = jCnt;
    drainNxt = drainCnt;
    stageNxt = stage;
    busyNxt  = busy;
    doneNxt  = 1'b0;
    rdEnNxt  = 1'b0;
    addrANxt = rd_addr_a;
    addrBNxt = rd_addr_b;
    twNxt    = tw_addr;
    unique case (state)
      IDLE: begin
        if (start) begin
          stateNxt = RUN;
          jNxt     = '0;
          stageNxt = firstStage;
          busyNxt  = 1'b1;
        end
      end
      RUN: begin
        if (!stall) begin
          rdEnNxt  = 1'b1;
          addrANxt = issueA;
          addrBNxt = issueB;
          twNxt    = issueTw;
          if (jCnt == J_LAST) begin
            stateNxt = DRAIN;
            drainNxt = '0;
          end else begin
            jNxt = jCnt + JW'(1);
          end
        end
      end
      DRAIN: begin
        drainNxt = drainCnt + DW'(1);
        // The next stage's first read may overlap the last write; the final stage
        // waits one more cycle so done lands after that write.
        if (!lastStage && drainCnt == DW'(PIPE_LAT - 1)) begin
          stateNxt = RUN;
          stageNxt = stageStep;
          jNxt     = '0;
        end else if (lastStage && drainCnt == DW'(PIPE_LAT)) begin
          stateNxt = FIN;
          busyNxt  = 1'b0;
          doneNxt  = 1'b1;
        end
      end
      FIN: begin
        stateNxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      jCnt      <= '0;
      drainCnt  <= '0;
      stage     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      rd_en     <= 1'b0;
      rd_addr_a <= '0;
      rd_addr_b <= '0;
      tw_addr   <= '0;
    end else begin
      state     <= stateNxt;
      jCnt      <= jNxt;
      drainCnt  <= drainNxt;
      stage     <= stageNxt;
      busy      <= busyNxt;
      done      <= doneNxt;
      rd_en     <= rdEnNxt;
      rd_addr_a <= addrANxt;
      rd_addr_b <= addrBNxt;
      tw_addr   <= twNxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      delayLine <= '0;
    end else begin
      delayLine[0] <= '{en: rd_en, a: rd_addr_a, b: rd_addr_b};
      for (int i = 1; i < PIPE_LAT; i++) begin
        delayLine[i] <= delayLine[i-1];
      end
    end
  end

  assign wr_en     = delayLine[PIPE_LAT-1].en;
  assign wr_addr_a = delayLine[PIPE_LAT-1].a;
  assign wr_addr_b = delayLine[PIPE_LAT-1].b;

endmodule

// File: tb/tb_ntt_butterfly_sequencer.sv
// Randomized bench for ntt_butterfly_sequencer against a schedule model built from the butterfly
// address rules and the per-stage cycle budget (N/2 issues plus PIPE_LAT drain).
module tb_ntt_butterfly_sequencer;
  localparam int LOG_N    = 8;
  localparam int PIPE_LAT = 4;
  localparam int HALF     = 1 << (LOG_N - 1);
  localparam int TOTAL    = LOG_N * HALF;
  localparam int RUN_CYC  = LOG_N * (HALF + PIPE_LAT) + 2;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic stall = 1'b0;
  logic busy, done, rd_en, wr_en;
  logic [3:0] stage;
  logic [LOG_N-1:0] rd_addr_a, rd_addr_b, wr_addr_a, wr_addr_b;
  logic [LOG_N-2:0] tw_addr;
`ifdef NTT_INVERSE_EN
  logic inverse = 1'b0;
  logic tw_inv;
`endif

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int startCyc, issueK, writeK, stallK, stallLen, doneSeen, doneCyc, busyCyc;
  int issueCycQ[$];
  int rdPerStage[LOG_N];
  bit monOn = 1'b0;
  bit invMode = 1'b0;

  ntt_butterfly_sequencer #(.LOG_N(LOG_N), .PIPE_LAT(PIPE_LAT)) dut (
    .clk(clk), .rst(rst), .start(start), .stall(stall),
`ifdef NTT_INVERSE_EN
    .inverse(inverse), .tw_inv(tw_inv),
`endif
    .busy(busy), .done(done), .stage(stage),
    .rd_en(rd_en), .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b), .tw_addr(tw_addr),
    .wr_en(wr_en), .wr_addr_a(wr_addr_a), .wr_addr_b(wr_addr_b)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input longint obs, input longint exp);
    checks++;
    if (obs != exp) begin
      failures++;
      $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // k counts butterflies in issue order across the whole transform.
  function automatic int stageOf(int k);
    int s = k / HALF;
    return invMode ? (LOG_N - 1 - s) : s;
  endfunction

  function automatic longint expRd(int k);
    int s  = stageOf(k);
    int j  = k % HALF;
    int m  = 1 << s;
    int a  = (j / m) * 2 * m + (j % m);
    int b  = a + m;
    int tw = (j % m) * (HALF / m);
    return (longint'(s) << (3*LOG_N - 1)) | (longint'(a) << (2*LOG_N - 1)) |
           (longint'(b) << (LOG_N - 1)) | longint'(tw);
  endfunction

  function automatic longint expWr(int k);
    int s = stageOf(k);
    int j = k % HALF;
    int m = 1 << s;
    int a = (j / m) * 2 * m + (j % m);
    return (longint'(a) << LOG_N) | longint'(a + m);
  endfunction

  function automatic int expIssueCyc(int k);
    return startCyc + 2 + (k / HALF) * (HALF + PIPE_LAT) + (k % HALF) + ((k >= stallK) ? stallLen : 0);
  endfunction

  always @(negedge clk) begin
    if (monOn) begin
      if (busy) busyCyc++;
      if (done) begin
        doneSeen++;
        doneCyc = cyc;
      end
      if (rd_en) begin
        if (issueK < TOTAL) begin
          chk("rd_fields", {stage, rd_addr_a, rd_addr_b, tw_addr}, expRd(issueK));
          chk("rd_cycle", cyc, expIssueCyc(issueK));
        end
        if (int'(stage) < LOG_N) rdPerStage[int'(stage)]++;
`ifdef NTT_INVERSE_EN
        chk("tw_inv", tw_inv, invMode);
`endif
        issueCycQ.push_back(cyc);
        issueK++;
      end
      if (wr_en) begin
        if (issueCycQ.size() > 0) chk("wr_latency", cyc - issueCycQ.pop_front(), PIPE_LAT);
        if (writeK < TOTAL) chk("wr_addr", {wr_addr_a, wr_addr_b}, expWr(writeK));
        writeK++;
      end
    end
  end

  task automatic clearStats(input int sK, input int sLen, input bit inv);
    issueK = 0; writeK = 0; doneSeen = 0; doneCyc = 0; busyCyc = 0;
    issueCycQ.delete();
    for (int s = 0; s < LOG_N; s++) rdPerStage[s] = 0;
    stallK = sK; stallLen = sLen; invMode = inv;
  endtask

  task automatic chkQuiet(input string pfx);
    chk({pfx, "_busy"}, busy, 0);
    chk({pfx, "_done"}, done, 0);
    chk({pfx, "_stage"}, stage, 0);
    chk({pfx, "_rd_en"}, rd_en, 0);
    chk({pfx, "_rd_addr_a"}, rd_addr_a, 0);
    chk({pfx, "_rd_addr_b"}, rd_addr_b, 0);
    chk({pfx, "_tw_addr"}, tw_addr, 0);
    chk({pfx, "_wr_en"}, wr_en, 0);
    chk({pfx, "_wr_addr_a"}, wr_addr_a, 0);
    chk({pfx, "_wr_addr_b"}, wr_addr_b, 0);
  endtask

  task automatic runXfer(input int sK, input int sLen, input bit holdStart, input bit inv);
    clearStats(sK, sLen, inv);
    repeat ($urandom_range(1, 5)) @(posedge clk);
    #1;
    start = 1'b1;
`ifdef NTT_INVERSE_EN
    inverse = inv;
`endif
    startCyc = cyc;
    monOn = 1'b1;
    if (!holdStart) begin
      @(posedge clk);
      #1 start = 1'b0;
`ifdef NTT_INVERSE_EN
      inverse = 1'b0;
`endif
    end
    if (sLen > 0) begin
      for (int i = 0; i < 2 * RUN_CYC && issueK < sK; i++) begin
        @(negedge clk);
        #1;
      end
      stall = 1'b1;
      repeat (sLen) @(posedge clk);
      #1 stall = 1'b0;
    end
    for (int i = 0; i < 2 * RUN_CYC && doneSeen == 0; i++) begin
      @(negedge clk);
      #1;
    end
    if (holdStart) begin
      @(posedge clk);
      #1 start = 1'b0;
`ifdef NTT_INVERSE_EN
      inverse = 1'b0;
`endif
    end
    repeat (6) @(negedge clk);
    #1;
    monOn = 1'b0;
    chk("done_count", doneSeen, 1);
    chk("done_cycle", doneCyc - startCyc, RUN_CYC + sLen);
    chk("busy_cycles", busyCyc, RUN_CYC - 1 + sLen);
    chk("issue_total", issueK, TOTAL);
    chk("write_total", writeK, TOTAL);
    for (int s = 0; s < LOG_N; s++) chk("stage_issues", rdPerStage[s], HALF);
    chk("idle_busy", busy, 0);
  endtask

  initial begin
    int rk, rl;
    repeat (3) @(posedge clk);
    #1;
    chkQuiet("reset");
    rst = 1'b1;

    // Abort mid-transform with an asynchronous reset.
    clearStats(TOTAL, 0, 1'b0);
    @(posedge clk);
    #1 start = 1'b1;
    startCyc = cyc;
    monOn = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    for (int i = 0; i < 2 * RUN_CYC && issueK < HALF + 20; i++) begin
      @(negedge clk);
      #1;
    end
    @(posedge clk);
    #3 rst = 1'b0;
    #1;
    chkQuiet("abort");
    clearStats(TOTAL, 0, 1'b0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b1;
    repeat (30) @(negedge clk);
    #1;
    chk("abort_busy", busy, 0);
    chk("abort_no_done", doneSeen, 0);
    chk("abort_no_issue", issueK, 0);
    chk("abort_no_write", writeK, 0);
    chk("abort_busy_cycles", busyCyc, 0);
    monOn = 1'b0;

    runXfer(TOTAL, 0, 1'b0, 1'b0);
    runXfer(2 * HALF + 40, 10, 1'b0, 1'b0);
    rk = int'($urandom_range(0, LOG_N - 1)) * HALF + int'($urandom_range(1, HALF - 1));
    rl = int'($urandom_range(1, 20));
    runXfer(rk, rl, 1'b0, 1'b0);
    runXfer(TOTAL, 0, 1'b1, 1'b0);
    runXfer(TOTAL, 0, 1'b0, 1'b0);
`ifdef NTT_INVERSE_EN
    runXfer(TOTAL, 0, 1'b0, 1'b1);
    rk = int'($urandom_range(0, LOG_N - 1)) * HALF + int'($urandom_range(1, HALF - 1));
    rl = int'($urandom_range(1, 20));
    runXfer(rk, rl, 1'b0, 1'b1);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ntt_butterfly_sequencer.md
Name: ntt_butterfly_sequencer

Overview:
- Top-level schedule controller for the in-place radix-2 NTT datapath over an N = 2^LOG_N coefficient memory.
- Issues one butterfly per cycle: paired read addresses and a twiddle ROM address, then the matching paired write addresses after the butterfly pipeline latency.
- Runs all LOG_N stages back to back, inserting a drain barrier between stages so there is no read-after-write hazard.
- Provides the start/busy/done handshake to the host.

Parameters:
- LOG_N, 8, log2 of transform length (N=256); legal range 2..15.
- PIPE_LAT, 4, cycles from read issue to write of the same butterfly; must be >= 1.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  reset; one clock; asynchronous, active-low (0 = reset).
- start  in  1  begin transform; sampled only in IDLE.
- stall  in  1  freeze butterfly issue for this cycle.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  single-cycle completion pulse.
- stage  out  4  current stage index, 0..LOG_N-1.
- rd_en  out  1  read/issue strobe.
- rd_addr_a  out  LOG_N  butterfly upper-operand address.
- rd_addr_b  out  LOG_N  butterfly lower-operand address.
- tw_addr  out  LOG_N-1  twiddle ROM address.
- wr_en  out  1  write strobe.
- wr_addr_a  out  LOG_N  write-back address for the upper operand.
- wr_addr_b  out  LOG_N  write-back address for the lower operand.

Behaviour:
- Reset:
  - FSM goes to IDLE.
  - All outputs are 0, including stage, all addresses and strobes.
  - Write delay line is cleared.
  - Reset mid-transform aborts immediately; no done pulse is produced.
- FSM states: IDLE, RUN, DRAIN, FIN.
  - IDLE: when start=1, load stage=0 and j=0, set busy=1 next cycle, go to RUN.
  - RUN: each cycle with stall=0, assert rd_en and output the addresses for (stage, j), then j++. When j = N/2-1 is issued, go to DRAIN. With stall=1, rd_en=0, j holds and the bubble propagates down the delay line.
  - DRAIN: count PIPE_LAT cycles with no issue; stall is ignored. At the end, if stage < LOG_N-1, do stage++, j=0 and go to RUN. Otherwise go to FIN.
  - FIN: done=1 and busy=0 for one cycle, then IDLE.
- Address arithmetic, with m = 1<<stage, grp = j>>stage, idx = j & (m-1):
  - rd_addr_a = (grp<<(stage+1)) | idx.
  - rd_addr_b = rd_addr_a + m.
  - tw_addr = idx << (LOG_N-1-stage), truncated to LOG_N-1 bits.
  - j is LOG_N-1 bits and wraps to 0 only via stage advance.
- Write path:
  - {rd_en, rd_addr_a, rd_addr_b} pass through a PIPE_LAT-deep shift register to produce {wr_en, wr_addr_a, wr_addr_b}.
  - wr_en rises exactly PIPE_LAT cycles after the corresponding rd_en.
  - The shift register advances every cycle regardless of stall.
- Outputs are registered. When rd_en=0, the rd_addr and tw_addr outputs hold their last values.
- The final wr_en occurs in the last DRAIN cycle. done follows in the next cycle.
- Total cycles from the start edge to done with no stall: LOG_N*(N/2+PIPE_LAT)+2, i.e. 1058 at the defaults.
- start while busy=1 or during FIN is ignored. Simultaneous start and done (FIN cycle) is ignored.
- stall held indefinitely keeps the block in RUN with no issue; this is legal.

Optional Feature:
- Macro: NTT_INVERSE_EN.
- Defined:
  - Adds input port inverse (1 bit), latched when start is accepted.
  - When latched high, stages run in descending order, LOG_N-1 down to 0 (Gentleman-Sande order), with the same per-stage address formulas.
  - tw_addr is unchanged; output tw_inv (1 bit) = latched inverse, selecting the inverse twiddle ROM.
  - Cycle count is unchanged.
- Undefined: no inverse or tw_inv ports; forward order only.

Test Plan:
- Reset/idle: rst=0 asynchronously mid-cycle during RUN -> all outputs 0 immediately; after release, IDLE, busy=0, and no done pulse.
- Stage 0 pattern (defaults): start pulse -> first three issues are (a,b,tw) = (0,1,0), (2,3,0), (4,5,0); wr_en is first high 4 cycles after the first rd_en, with wr addresses (0,1).
- Mid/last stage pattern:
  - stage=1, j=3 -> (5,7,64).
  - stage=7, j=5 -> (5,133,5).
  - Every stage issues exactly 128 rd_en and 128 wr_en.
- Full run timing: no stall -> done exactly 1058 cycles after the start edge; busy is high for 1057 cycles; stage steps 0..7; no issue during each 4-cycle drain.
- Stall: stall=1 for 10 cycles in stage 2 at j=40 -> j resumes at 40 with no skipped or duplicated addresses; done is delayed by exactly 10 cycles; wr_en shows a matching 10-cycle gap.
- Handshake edges: start held high for the whole transform -> exactly one transform, no restart in FIN; next transform starts only after IDLE. With NTT_INVERSE_EN and inverse=1, stage order is 7..0 and tw_inv=1.
